// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - segment constants and hex-to-segment decode shared by the scan driver
package sevseg_pkg;

    // Active-low patterns, bit order g..a
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/sevseg_hex_decoder.sv
// rtl/sevseg_hex_decoder.sv - combinational hex nibble to active-low segment decoder
module sevseg_hex_decoder (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);
    import sevseg_pkg::*;

    assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/sevseg_scan_driver.sv
// rtl/sevseg_scan_driver.sv - multiplexed N-digit common-anode driver with frame-synchronous load,
// leading-zero blanking and PWM brightness
module sevseg_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int CLK_DIV     = 100000,
    parameter int BRIGHT_BITS = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    input  logic                    i_blank_lz,
    input  logic [BRIGHT_BITS-1:0]  i_brightness,
    input  logic                    i_load,
    output logic [7:0]              o_ca,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame_done
);
    import sevseg_pkg::*;

    localparam int PRESC_W = $clog2(CLK_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [PRESC_W-1:0]      r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [BRIGHT_BITS-1:0]  r_pwm;

    logic [4*NUM_DIGITS-1:0] r_pend_data, r_com_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp,   r_com_dp;
    logic [NUM_DIGITS-1:0]   r_pend_en,   r_com_en;
    logic                    r_pend_blz,  r_com_blz;

    logic [7:0]              r_ca;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_tick;
    logic                    w_boundary;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_zero_above;
    logic [3:0]              w_nibble;
    logic                    w_dp;
    logic                    w_blank_cur;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_an_next;

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_boundary = w_tick && (r_idx == IDX_LAST);

    // A digit is blanked only if it and every more-significant nibble are zero
    always_comb begin
        w_blank      = '0;
        w_zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above && (r_com_data[4*i +: 4] == 4'h0);
            w_blank[i]   = r_com_blz && w_zero_above;
        end
    end

    always_comb begin
        w_nibble    = 4'h0;
        w_dp        = 1'b0;
        w_blank_cur = 1'b0;
        w_an_next   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble    = r_com_data[4*i +: 4];
                w_dp        = r_com_dp[i];
                w_blank_cur = w_blank[i];
                w_an_next[i] = !(r_com_en[i] && (r_pwm <= i_brightness));
            end
        end
    end

    sevseg_hex_decoder u_hex_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_pwm        <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_en    <= '0;
            r_pend_blz   <= 1'b0;
            r_com_data   <= '0;
            r_com_dp     <= '0;
            r_com_en     <= '0;
            r_com_blz    <= 1'b0;
            r_ca         <= 8'hFF;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_presc      <= w_tick ? '0 : r_presc + PRESC_W'(1);
            r_pwm        <= r_pwm + BRIGHT_BITS'(1);
            r_frame_done <= w_boundary;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end
            if (i_load) begin
                r_pend_data <= i_data;
                r_pend_dp   <= i_dp_in;
                r_pend_en   <= i_digit_en;
                r_pend_blz  <= i_blank_lz;
            end
            // Committed image only changes at the frame boundary, so a frame never tears
            if (w_boundary) begin
                r_com_data <= i_load ? i_data     : r_pend_data;
                r_com_dp   <= i_load ? i_dp_in    : r_pend_dp;
                r_com_en   <= i_load ? i_digit_en : r_pend_en;
                r_com_blz  <= i_load ? i_blank_lz : r_pend_blz;
            end
            r_ca <= {~w_dp, w_blank_cur ? SEG_BLANK : w_seg};
            r_an <= w_an_next;
        end
    end

    assign o_ca         = r_ca;
    assign o_an         = r_an;
    assign o_frame_done = r_frame_done;

endmodule
